regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width of the register file write port.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 Port alu_valid, input, 1, ALU writeback request.
REQ-006 Port alu_ready, output, 1, ALU request granted this cycle.
REQ-007 Port alu_reg, input, ADDR_W, ALU destination register.
REQ-008 Port alu_data, input, DATA_W, ALU result.
REQ-009 Port mem_valid, input, 1, load writeback request.
REQ-010 Port mem_ready, output, 1, load request granted this cycle.
REQ-011 Port mem_reg, input, ADDR_W, load destination register.
REQ-012 Port mem_data, input, DATA_W, load data.
REQ-013 Port reg_write, output, 1, write enable to register file.
REQ-014 Port write_reg, output, ADDR_W, register file write index.
REQ-015 Port write_data, output, DATA_W, register file write data.
REQ-016 Port last_grant, output, 1, requester granted most recently (0 = ALU, 1 = MEM).

Function
REQ-017 Transfer on a port SHALL occur in a cycle where its valid and ready are both high; requesters hold valid, reg and data stable until transfer.
REQ-018 ready outputs SHALL be combinational from valid and last_grant; at most one ready high per cycle; ready never high while its valid is low.
REQ-019 One valid only: that requester SHALL be granted in the same cycle.
REQ-020 Both valid: grant SHALL go to the requester not equal to last_grant (round-robin); neither requester waits more than one cycle.
REQ-021 last_grant SHALL update to the granted requester on each transfer and hold otherwise.
REQ-022 Write port outputs SHALL be registered: transfer in cycle N drives reg_write=1, write_reg, write_data in cycle N+1 (latency 1); with no transfer, reg_write=0 in N+1.
REQ-023 Transfer targeting register 0 SHALL be accepted (ready high, last_grant updates) but produce reg_write=0 in N+1.
REQ-024 Back-to-back transfers SHALL sustain one write per cycle; no bubble between consecutive grants.
REQ-025 Both requesters targeting the same register: SHALL be serialized in round-robin order; the later-granted value is the final register content.
REQ-026 write_reg and write_data SHALL hold their last value when reg_write=0.

Reset
REQ-027 rst_n low at a rising edge SHALL set reg_write=0, write_reg=0, write_data=0, last_grant=1 (ALU wins first contention).
REQ-028 While rst_n is low, alu_ready and mem_ready SHALL be 0; a transfer in progress is dropped, no write issued after reset.
REQ-029 First grant SHALL be possible in the first cycle with rst_n high.

Structure
REQ-030 Shared package SHALL hold DATA_W/ADDR_W defaults, ZERO_REG constant and GRANT_ALU/GRANT_MEM encodings.
REQ-031 Grant logic SHALL be one sub-module rr_arbiter2 (2-way round-robin: valids and last_grant in, one-hot grant out); datapath mux and output register stay in the top.

Verification
REQ-032 After reset, alu_valid=1, alu_reg=5, alu_data=ABCD1234 -> alu_ready=1 same cycle; next cycle reg_write=1, write_reg=5, write_data=ABCD1234.
REQ-033 Both valid for 4 cycles (alu->reg 10, mem->reg 11) -> grants ALU, MEM, ALU, MEM; writes to 10, 11, 10, 11 one per cycle.
REQ-034 mem_valid=1, mem_reg=0, mem_data=FFFFFFFF -> mem_ready=1, last_grant=1, reg_write=0 next cycle.
REQ-035 Both valid targeting reg 5 (alu=11111111, mem=87654321), last_grant=0 -> MEM written first, ALU second; final write_data=11111111.
REQ-036 rst_n low in cycle following a grant -> reg_write=0, readies 0, last_grant=1; after release, simultaneous requests grant ALU first.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register-0 index and last_grant encodings for the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ALU and load writeback requests plus the register-file write port, grouped into one bundle.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;

  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              last_grant;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready,
    input  reg_write, write_reg, write_data, last_grant
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready,
    output reg_write, write_reg, write_data, last_grant
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: purely combinational, one-hot o_grant ([0]=ALU, [1]=MEM).
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       i_alu_valid,
  input  logic       i_mem_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  logic w_alu_pref;

  // On contention the side that did not win last time goes next.
  assign w_alu_pref = (i_last_grant == GRANT_MEM);

  assign o_grant[0] = i_alu_valid && (!i_mem_valid || w_alu_pref);
  assign o_grant[1] = i_mem_valid && (!i_alu_valid || !w_alu_pref);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks onto one register-file write port; grant is same-cycle,
// write appears one cycle after transfer, and the losing requester holds for at most one cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_arbiter_if.slave wb
);

  logic [1:0]        w_grant;
  logic              w_alu_rdy;
  logic              w_mem_rdy;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_do_write;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_last_grant;

  rr_arbiter2 u_arb (
    .i_alu_valid  (wb.alu_valid),
    .i_mem_valid  (wb.mem_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Readies are suppressed during reset so nothing is accepted that would be lost.
  assign w_alu_rdy  = rst_n && w_grant[0];
  assign w_mem_rdy  = rst_n && w_grant[1];
  assign w_xfer     = w_alu_rdy || w_mem_rdy;

  assign w_sel_reg  = w_mem_rdy ? wb.mem_reg  : wb.alu_reg;
  assign w_sel_data = w_mem_rdy ? wb.mem_data : wb.alu_data;
  assign w_do_write = w_xfer && (w_sel_reg != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_last_grant <= GRANT_MEM;
    end else begin
      r_reg_write <= w_do_write;
      // Index/data only move on a real write so they hold across idle and reg-0 cycles.
      if (w_do_write) begin
        r_write_reg  <= w_sel_reg;
        r_write_data <= w_sel_data;
      end
      if (w_xfer) begin
        r_last_grant <= w_mem_rdy ? GRANT_MEM : GRANT_ALU;
      end
    end
  end

  assign wb.alu_ready  = w_alu_rdy;
  assign wb.mem_ready  = w_mem_rdy;
  assign wb.reg_write  = r_reg_write;
  assign wb.write_reg  = r_write_reg;
  assign wb.write_data = r_write_data;
  assign wb.last_grant = r_last_grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed stimulus; readies checked at issue, write port checked by a scoreboard monitor.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  bit mon_en = 0;

  // Reference model state: who won last, what the write port should show, register contents.
  logic          m_last = 1'b1;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_wreg = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] dut_rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check readies against the model, advance the model, queue the expected write port.
  task automatic step(output int dg);
    int g;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    exp_t e;
    #1;
    g = -1;
    if (rst_n) begin
      if (bus.alu_valid && bus.mem_valid) g = (m_last == 1'b1) ? 0 : 1;
      else if (bus.alu_valid) g = 0;
      else if (bus.mem_valid) g = 1;
    end
    dg = bus.alu_ready ? 0 : (bus.mem_ready ? 1 : -1);
    chk("alu_ready", 64'(bus.alu_ready), 64'(g == 0));
    chk("mem_ready", 64'(bus.mem_ready), 64'(g == 1));
    if (!rst_n) begin
      m_last = 1'b1; m_wr = 1'b0; m_wreg = '0; m_wdata = '0;
    end else if (g >= 0) begin
      r = (g == 1) ? bus.mem_reg : bus.alu_reg;
      d = (g == 1) ? bus.mem_data : bus.alu_data;
      m_last = (g == 1);
      m_wr = (r != 0);
      if (m_wr) begin
        m_wreg = r; m_wdata = d; m_rf[r] = d;
      end
    end else begin
      m_wr = 1'b0;
    end
    e.wr = m_wr; e.wreg = m_wreg; e.wdata = m_wdata; e.last = m_last;
    exp_q.push_back(e);
    mon_en = 1;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("reg_write",  64'(bus.reg_write),  64'(e.wr));
          chk("write_reg",  64'(bus.write_reg),  64'(e.wreg));
          chk("write_data", 64'(bus.write_data), 64'(e.wdata));
          chk("last_grant", 64'(bus.last_grant), 64'(e.last));
        end
        if (bus.reg_write) dut_rf[bus.write_reg] = bus.write_data;
      end
    end
  end

  task automatic idle();
    bus.alu_valid = 0; bus.mem_valid = 0;
  endtask

  initial begin
    int dg;
    int exp_seq[4] = '{0, 1, 0, 1};
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; dut_rf[i] = '0; end
    bus.alu_valid = 0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_reg = '0; bus.mem_data = '0;
    rst_n = 0;
    @(negedge clk);
    step(dg);
    bus.alu_valid = 1; bus.mem_valid = 1;
    step(dg);
    chk("rst_no_grant", 64'(dg), 64'(-1));
    idle();
    rst_n = 1;

    // Single ALU request granted immediately, written next cycle.
    bus.alu_valid = 1; bus.alu_reg = 5; bus.alu_data = 32'hABCD1234;
    step(dg);
    chk("t32_grant", 64'(dg), 64'd0);
    chk("t32_wr", 64'(bus.reg_write), 64'd1);
    chk("t32_reg", 64'(bus.write_reg), 64'd5);
    chk("t32_data", 64'(bus.write_data), 64'hABCD1234);
    idle();

    // Load to register 0: accepted, no write, write port holds.
    bus.mem_valid = 1; bus.mem_reg = 0; bus.mem_data = 32'hFFFFFFFF;
    step(dg);
    chk("t34_grant", 64'(dg), 64'd1);
    chk("t34_wr", 64'(bus.reg_write), 64'd0);
    chk("t34_last", 64'(bus.last_grant), 64'd1);
    chk("t34_hold", 64'(bus.write_data), 64'hABCD1234);
    idle();

    // Sustained contention alternates with no bubbles.
    bus.alu_valid = 1; bus.alu_reg = 10; bus.alu_data = 32'h0A0A0A0A;
    bus.mem_valid = 1; bus.mem_reg = 11; bus.mem_data = 32'h0B0B0B0B;
    for (int i = 0; i < 4; i++) begin
      step(dg);
      chk("t33_grant", 64'(dg), 64'(exp_seq[i]));
      chk("t33_reg", 64'(bus.write_reg), (exp_seq[i] == 0) ? 64'd10 : 64'd11);
      chk("t33_wr", 64'(bus.reg_write), 64'd1);
    end
    idle();

    // Same-register collision with ALU granted last: MEM first, ALU value survives.
    bus.alu_valid = 1; bus.alu_reg = 3; bus.alu_data = 32'h33333333;
    step(dg);
    bus.alu_reg = 5; bus.alu_data = 32'h11111111;
    bus.mem_valid = 1; bus.mem_reg = 5; bus.mem_data = 32'h87654321;
    step(dg);
    chk("t35_first", 64'(dg), 64'd1);
    chk("t35_data1", 64'(bus.write_data), 64'h87654321);
    bus.mem_valid = 0;
    step(dg);
    chk("t35_second", 64'(dg), 64'd0);
    chk("t35_data2", 64'(bus.write_data), 64'h11111111);
    chk("t35_final", 64'(dut_rf[5]), 64'h11111111);
    idle();

    // Reset right after a grant drops everything; ALU wins first contention afterwards.
    bus.alu_valid = 1; bus.alu_reg = 7; bus.alu_data = 32'h77777777;
    bus.mem_valid = 0;
    step(dg);
    rst_n = 0; bus.mem_valid = 1;
    step(dg);
    chk("t36_rst_grant", 64'(dg), 64'(-1));
    chk("t36_rst_wr", 64'(bus.reg_write), 64'd0);
    chk("t36_rst_last", 64'(bus.last_grant), 64'd1);
    rst_n = 1;
    step(dg);
    chk("t36_first", 64'(dg), 64'd0);
    idle();

    // Random traffic: requesters hold until granted, occasional reset.
    for (int c = 0; c < 600; c++) begin
      if (!bus.alu_valid && $urandom_range(0, 9) < 6) begin
        bus.alu_valid = 1;
        bus.alu_reg = AW'($urandom_range(0, 7));
        bus.alu_data = $urandom;
      end
      if (!bus.mem_valid && $urandom_range(0, 9) < 6) begin
        bus.mem_valid = 1;
        bus.mem_reg = AW'($urandom_range(0, 7));
        bus.mem_data = $urandom;
      end
      rst_n = ($urandom_range(0, 99) != 0);
      step(dg);
      if (dg == 0) bus.alu_valid = 0;
      if (dg == 1) bus.mem_valid = 0;
    end
    rst_n = 1;
    idle();
    step(dg);
    for (int i = 1; i < 8; i++) chk("rf_final", 64'(dut_rf[i]), 64'(m_rf[i]));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
